// File: rtl/spm_pkg.sv
// rtl/spm_pkg.sv - shared types and sizing for the serial-parallel multiplier sequencer
package spm_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } spm_state_t;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_LAT   = 2;

  // Wide enough to hold LAT+2*WIDTH so the SHIFT count never wraps.
  function automatic int cnt_width(input int lat, input int width);
    return $clog2(lat + 2 * width + 1);
  endfunction

endpackage

// File: rtl/spm_deser.sv
// rtl/spm_deser.sv - LSB-first serial-to-parallel product capture register
module spm_deser #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         bit_in,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;

  // Bits enter at the top and walk down, so the first captured bit ends in q[0].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else if (clr) begin
      q_q <= '0;
    end else if (en) begin
      q_q <= {bit_in, q_q[W-1:1]};
    end
  end

  assign q = q_q;

endmodule

// File: rtl/spm_ctrl.sv
// rtl/spm_ctrl.sv - sequencer: operand handshake, load/shift control, product return
import spm_pkg::*;

module spm_ctrl #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LAT   = DEF_LAT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  input  logic               abort,
  output logic [WIDTH-1:0]   spm_x,
  output logic [WIDTH-1:0]   spm_y,
  output logic               spm_ld,
  input  logic               spm_p,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int            CW     = cnt_width(LAT, WIDTH);
  localparam logic [CW-1:0] LAT_C  = CW'(LAT);
  localparam logic [CW-1:0] LAST_C = CW'(LAT + 2 * WIDTH - 1);

  spm_state_t       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] spm_x_q;
  logic [WIDTH-1:0] spm_y_q;
  logic             spm_ld_q;
  logic             out_valid_q;

  logic accept;
  logic abort_act;
  logic cap_clr;
  logic cap_en;

  assign accept    = in_valid && (state_q == S_IDLE);
  assign abort_act = abort && (state_q != S_IDLE);
  assign cap_clr   = accept || abort_act;
  // The first LAT shift cycles carry array pipeline fill, not product bits.
  assign cap_en    = (state_q == S_SHIFT) && (cnt_q >= LAT_C);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      spm_x_q     <= '0;
      spm_y_q     <= '0;
      spm_ld_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (abort_act) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      spm_ld_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            spm_x_q  <= in_x;
            spm_y_q  <= in_y;
            spm_ld_q <= 1'b1;
            state_q  <= S_LOAD;
          end
        end
        S_LOAD: begin
          spm_ld_q <= 1'b0;
          cnt_q    <= '0;
          state_q  <= S_SHIFT;
        end
        S_SHIFT: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_C) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  spm_deser #(
    .W(2 * WIDTH)
  ) u_deser (
    .clk   (clk),
    .rst   (rst),
    .clr   (cap_clr),
    .en    (cap_en),
    .bit_in(spm_p),
    .q     (out_p)
  );

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign spm_x     = spm_x_q;
  assign spm_y     = spm_y_q;
  assign spm_ld    = spm_ld_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_spm_ctrl.sv
// tb/tb_spm_ctrl.sv - directed self-checking bench for spm_ctrl (WIDTH=8, LAT=2)
module tb_spm_ctrl;

  localparam int W = 8;
  localparam int L = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_x = '0;
  logic [W-1:0] in_y = '0;
  logic         abort = 1'b0;
  logic [W-1:0] spm_x;
  logic [W-1:0] spm_y;
  logic         spm_ld;
  logic         spm_p;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [2*W-1:0] out_p;
  logic         busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Array model: true product presented LSB-first, L cycles after the load.
  logic [2*W-1:0] prod = '0;
  int             sc   = 1000;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (spm_ld) begin
      prod <= spm_x * spm_y;
      sc   <= 0;
    end else if (sc < 1000) begin
      sc <= sc + 1;
    end
  end

  assign spm_p = (sc >= L && sc < L + 2 * W) ? prod[sc-L] : 1'b0;

  spm_ctrl #(.WIDTH(W), .LAT(L)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_y     (in_y),
    .abort    (abort),
    .spm_x    (spm_x),
    .spm_y    (spm_y),
    .spm_ld   (spm_ld),
    .spm_p    (spm_p),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_p    (out_p),
    .busy     (busy)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Present an operand pair for one edge; afterwards we sit in cycle t+1.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    cyc = 0;
    tick();
    in_valid = 1'b0;
  endtask

  // Run until out_valid; checks arrival cycle and that spm_ld never re-fires.
  task automatic wait_out(input string tag, input logic [15:0] exp_p);
    int ld_seen;
    ld_seen = 0;
    while (!out_valid && cyc < 200) begin
      tick();
      if (spm_ld) ld_seen++;
    end
    chki({tag, "_lat"}, cyc, 20);
    chki({tag, "_ld_extra"}, ld_seen, 0);
    chk1({tag, "_valid"}, out_valid, 1'b1);
    chk16({tag, "_p"}, out_p, exp_p);
  endtask

  initial begin
    int bad;

    // Reset state
    #1;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk16("rst_out_p", out_p, 16'h0000);
    chk16("rst_spm_x", {8'h00, spm_x}, 16'h0000);
    chk16("rst_spm_ld", {15'h0, spm_ld}, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // 5 x 3, load strobe only at t+1
    out_ready = 1'b0;
    issue(8'd5, 8'd3);
    chk1("t1_ld", spm_ld, 1'b1);
    chk1("t1_busy", busy, 1'b1);
    chk1("t1_in_ready", in_ready, 1'b0);
    chk16("t1_spm_x", {8'h00, spm_x}, 16'h0005);
    chk16("t1_spm_y", {8'h00, spm_y}, 16'h0003);
    wait_out("t1", 16'h000F);
    out_ready = 1'b1;
    tick();
    chk1("t1_back_idle", in_ready, 1'b1);
    chk1("t1_valid_drop", out_valid, 1'b0);

    // FF x FF with consumer stalled for 10 cycles
    out_ready = 1'b0;
    issue(8'hFF, 8'hFF);
    wait_out("t2", 16'hFE01);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!(out_valid === 1'b1 && out_p === 16'hFE01 && in_ready === 1'b0)) bad++;
    end
    chki("t2_hold_bad_cycles", bad, 0);
    out_ready = 1'b1;
    tick();
    chk1("t2_in_ready_after", in_ready, 1'b1);

    // Back-to-back with out_ready tied high
    issue(8'h12, 8'h34);
    wait_out("t3a", 16'h03A8);
    chk1("t3_in_ready_t20", in_ready, 1'b0);
    tick();
    chki("t3_reissue_cycle", cyc, 21);
    chk1("t3_in_ready_t21", in_ready, 1'b1);
    issue(8'h00, 8'hAB);
    wait_out("t3b", 16'h0000);
    tick();

    // Abort in the 6th SHIFT cycle (t+7)
    out_ready = 1'b0;
    issue(8'h0F, 8'h0F);
    while (cyc < 7) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk1("t4_idle", in_ready, 1'b1);
    chk1("t4_busy", busy, 1'b0);
    chk1("t4_valid", out_valid, 1'b0);
    chk16("t4_out_p", out_p, 16'h0000);
    out_ready = 1'b1;
    issue(8'd7, 8'd9);
    wait_out("t4b", 16'h003F);
    tick();

    // Asynchronous reset mid-SHIFT
    issue(8'h0F, 8'h0F);
    while (cyc < 8) tick();
    rst = 1'b0;
    #1;
    chk1("t5_in_ready", in_ready, 1'b1);
    chk1("t5_busy", busy, 1'b0);
    chk1("t5_valid", out_valid, 1'b0);
    chk16("t5_out_p", out_p, 16'h0000);
    chk16("t5_spm_xy", {spm_x, spm_y}, 16'h0000);
    chk1("t5_ld", spm_ld, 1'b0);
    tick();
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    chki("t5_quiet_cycles", bad, 0);

    // in_valid during SHIFT is ignored
    issue(8'd3, 8'd4);
    while (cyc < 4) tick();
    in_valid = 1'b1;
    in_x = 8'hAA;
    in_y = 8'h55;
    while (cyc < 9) tick();
    chk16("t6_spm_xy", {spm_x, spm_y}, 16'h0304);
    chk1("t6_ld", spm_ld, 1'b0);
    in_valid = 1'b0;
    wait_out("t6", 16'h000C);
    tick();
    tick();
    chk1("t6_no_queue", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
